// File: rtl/spif_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | spif_arb_pkg: shared types and round-robin helper for arbiters  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package spif_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int c_default_burst_len = 8;
  localparam int c_max_pipes         = 32;
  localparam int c_ptr_w             = 5;

  // First set bit of i_req at or above i_start, wrapping at i_n.
  function automatic logic [c_ptr_w-1:0] rr_next(
    input logic [c_max_pipes-1:0] i_req,
    input logic [c_ptr_w-1:0]     i_start,
    input int                     i_n
  );
    logic [c_ptr_w-1:0] w_sel;
    logic               w_found;
    int                 w_j;
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 0; k < c_max_pipes; k++) begin
      w_j = int'(i_start) + k;
      if (w_j >= i_n) w_j = w_j - i_n;
      if (!w_found && (k < i_n) && i_req[w_j[c_ptr_w-1:0]]) begin
        w_sel   = w_j[c_ptr_w-1:0];
        w_found = 1'b1;
      end
    end
    return w_sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/evt_skid_buf.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | evt_skid_buf: two-entry (main + skid) ordered output buffer     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module evt_skid_buf #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_vld,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_rdy,
  output logic             o_rd_vld,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full
);

  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_main_vld;
  logic             r_skid_vld;
  logic             w_consume;

  assign w_consume = r_main_vld && i_rd_rdy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_consume) begin
      // Skid always holds the older entry, so it refills main before any new write.
      if (r_skid_vld) begin
        r_main     <= r_skid;
        r_skid_vld <= i_wr_vld;
        if (i_wr_vld) r_skid <= i_wr_data;
      end else begin
        r_main_vld <= i_wr_vld;
        if (i_wr_vld) r_main <= i_wr_data;
      end
    end else if (i_wr_vld) begin
      if (!r_main_vld) begin
        r_main     <= i_wr_data;
        r_main_vld <= 1'b1;
      end else begin
        r_skid     <= i_wr_data;
        r_skid_vld <= 1'b1;
      end
    end
  end

  assign o_rd_vld  = r_main_vld;
  assign o_rd_data = r_main;
  assign o_full    = r_skid_vld;

endmodule
`default_nettype wire

// File: rtl/evt_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | evt_arbiter: round-robin burst arbiter feeding pkt_assembler    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module evt_arbiter
  import spif_arb_pkg::*;
#(
  parameter int NUM_PIPES = 4,
  parameter int BURST_LEN = c_default_burst_len,
  parameter int IDX_BITS  = $clog2(NUM_PIPES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PIPES-1:0] arb_en_in,
  input  logic [31:0]          evt_data_in [NUM_PIPES],
  input  logic [NUM_PIPES-1:0] evt_vld_in,
  output logic [NUM_PIPES-1:0] evt_rdy_out,
  output logic [31:0]          evt_data_out,
  output logic [IDX_BITS-1:0]  evt_idx_out,
  output logic                 evt_vld_out,
  input  logic                 evt_rdy_in
);

  localparam int c_cnt_w = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int c_pay_w = IDX_BITS + 32;

  arb_state_t                 r_state;
  logic [IDX_BITS-1:0]        r_gnt;
  logic [IDX_BITS-1:0]        r_ptr;
  logic [c_cnt_w-1:0]         r_burst_cnt;

  logic [NUM_PIPES-1:0]       w_req;
  logic [NUM_PIPES-1:0]       w_rdy;
  logic [c_max_pipes-1:0]     w_req_ext;
  logic [c_ptr_w-1:0]         w_pick_full;
  logic [IDX_BITS-1:0]        w_pick;
  logic [IDX_BITS-1:0]        w_pick_inc;
  logic                       w_skid_full;
  logic                       w_gnt_vld;
  logic                       w_gnt_en;
  logic                       w_gnt_rdy;
  logic                       w_accept;
  logic                       w_release;
  logic [c_pay_w-1:0]         w_wr_data;
  logic [c_pay_w-1:0]         w_out_data;

  assign w_req       = evt_vld_in & arb_en_in;
  assign w_req_ext   = c_max_pipes'(w_req);
  assign w_pick_full = rr_next(w_req_ext, c_ptr_w'(r_ptr), NUM_PIPES);
  assign w_pick      = w_pick_full[IDX_BITS-1:0];
  assign w_pick_inc  = (w_pick == IDX_BITS'(NUM_PIPES - 1)) ? '0 : w_pick + IDX_BITS'(1);

  // Ready is combinational from arb_en_in so a disable takes effect in the same cycle.
  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_rdy
    assign w_rdy[i] = (r_state == GRANT) && (r_gnt == IDX_BITS'(i)) &&
                      arb_en_in[i] && !w_skid_full;
  end

  assign evt_rdy_out = w_rdy;
  assign w_gnt_vld   = evt_vld_in[r_gnt];
  assign w_gnt_en    = arb_en_in[r_gnt];
  assign w_gnt_rdy   = w_rdy[r_gnt];
  assign w_accept    = w_gnt_rdy && w_gnt_vld;
  assign w_release   = !w_gnt_en || (w_gnt_rdy && !w_gnt_vld) ||
                       (w_accept && (r_burst_cnt == c_cnt_w'(BURST_LEN - 1)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_ptr       <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_state     <= GRANT;
            r_gnt       <= w_pick;
            r_ptr       <= w_pick_inc;
            r_burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state <= IDLE;
          end else if (w_accept) begin
            r_burst_cnt <= r_burst_cnt + c_cnt_w'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_wr_data = {r_gnt, evt_data_in[r_gnt]};

  evt_skid_buf #(
    .WIDTH (c_pay_w)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_wr_vld  (w_accept),
    .i_wr_data (w_wr_data),
    .i_rd_rdy  (evt_rdy_in),
    .o_rd_vld  (evt_vld_out),
    .o_rd_data (w_out_data),
    .o_full    (w_skid_full)
  );

  assign evt_idx_out  = w_out_data[c_pay_w-1:32];
  assign evt_data_out = w_out_data[31:0];

endmodule
`default_nettype wire

// File: tb/tb_evt_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_evt_arbiter: directed self-checking bench for evt_arbiter    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_evt_arbiter;

  localparam int NP = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NP-1:0] arb_en_in;
  logic [31:0]   evt_data_in [NP];
  logic [NP-1:0] evt_vld_in;
  logic          evt_rdy_in;

  logic [NP-1:0] rdy_b1, rdy_b8, rdy_o;
  logic [31:0]   dat_b1, dat_b8, dat_o;
  logic [IW-1:0] idx_b1, idx_b8, idx_o;
  logic          vld_b1, vld_b8, vld_o;
  logic          use_b1;

  always #5 clk = ~clk;

  evt_arbiter #(.NUM_PIPES(NP), .BURST_LEN(1)) dut_b1 (
    .clk(clk), .reset(reset), .arb_en_in(arb_en_in), .evt_data_in(evt_data_in),
    .evt_vld_in(evt_vld_in), .evt_rdy_out(rdy_b1), .evt_data_out(dat_b1),
    .evt_idx_out(idx_b1), .evt_vld_out(vld_b1), .evt_rdy_in(evt_rdy_in)
  );

  evt_arbiter #(.NUM_PIPES(NP), .BURST_LEN(8)) dut_b8 (
    .clk(clk), .reset(reset), .arb_en_in(arb_en_in), .evt_data_in(evt_data_in),
    .evt_vld_in(evt_vld_in), .evt_rdy_out(rdy_b8), .evt_data_out(dat_b8),
    .evt_idx_out(idx_b8), .evt_vld_out(vld_b8), .evt_rdy_in(evt_rdy_in)
  );

  assign rdy_o = use_b1 ? rdy_b1 : rdy_b8;
  assign dat_o = use_b1 ? dat_b1 : dat_b8;
  assign idx_o = use_b1 ? idx_b1 : idx_b8;
  assign vld_o = use_b1 ? vld_b1 : vld_b8;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc;
  int          src_base [NP];
  int          src_cnt [NP];
  int          src_lim [NP];
  bit          src_on [NP];
  int          first_acc [NP];
  int          last_acc [NP];
  logic [33:0] log_q [$];
  int          log_cyc [$];
  logic [33:0] exp_q [$];
  bit          multi_rdy;
  bit          stall_chg;
  bit          held_v;
  logic [33:0] held;

  task automatic drive_src();
    for (int i = 0; i < NP; i++) begin
      evt_vld_in[i]  = src_on[i] && (src_cnt[i] < src_lim[i]);
      evt_data_in[i] = 32'(src_base[i] + src_cnt[i]);
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < NP; i++) begin
      src_on[i] = 1'b0; src_cnt[i] = 0; src_lim[i] = 0; src_base[i] = 0;
      first_acc[i] = -1; last_acc[i] = -1;
    end
    log_q.delete(); log_cyc.delete(); exp_q.delete();
    multi_rdy = 1'b0; stall_chg = 1'b0; held_v = 1'b0;
    drive_src();
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if ($countones(rdy_o) > 1) multi_rdy = 1'b1;
    if (held_v && ({idx_o, dat_o} !== held)) stall_chg = 1'b1;
    if (vld_o && !evt_rdy_in) begin held_v = 1'b1; held = {idx_o, dat_o}; end
    else held_v = 1'b0;
    if (vld_o && evt_rdy_in) begin log_q.push_back({idx_o, dat_o}); log_cyc.push_back(cyc); end
    for (int i = 0; i < NP; i++) begin
      if (evt_vld_in[i] && rdy_o[i]) begin
        src_cnt[i]++;
        if (first_acc[i] < 0) first_acc[i] = cyc;
        last_acc[i] = cyc;
      end
    end
    @(posedge clk);
    #1;
    drive_src();
  endtask

  task automatic do_reset();
    reset = 1'b0; arb_en_in = '1; evt_rdy_in = 1'b1;
    clear_src();
    tick(); tick();
    reset = 1'b1;
    clear_src();
    cyc = 0;
  endtask

  task automatic test_reset();
    use_b1 = 1'b0;
    reset = 1'b0; arb_en_in = '1; evt_rdy_in = 1'b1;
    clear_src();
    tick();
    n_chk++; if (rdy_b8 !== '0) $display("FAIL rst_rdy_b8: got %b expected 0000", rdy_b8); else n_pass++;
    n_chk++; if (vld_b8 !== 1'b0) $display("FAIL rst_vld_b8: got %b expected 0", vld_b8); else n_pass++;
    n_chk++; if (dat_b8 !== 32'h0) $display("FAIL rst_dat_b8: got %h expected 0", dat_b8); else n_pass++;
    n_chk++; if (idx_b8 !== 2'd0) $display("FAIL rst_idx_b8: got %0d expected 0", idx_b8); else n_pass++;
    n_chk++; if (rdy_b1 !== '0) $display("FAIL rst_rdy_b1: got %b expected 0000", rdy_b1); else n_pass++;
    n_chk++; if (vld_b1 !== 1'b0) $display("FAIL rst_vld_b1: got %b expected 0", vld_b1); else n_pass++;
  endtask

  task automatic test_fair_rotation();
    use_b1 = 1'b1;
    do_reset();
    for (int i = 0; i < NP; i++) begin
      src_on[i] = 1'b1; src_lim[i] = 3; src_base[i] = 16 * i;
    end
    drive_src();
    repeat (30) tick();
    n_chk++; if (log_q.size() != 12) $display("FAIL fair_count: got %0d expected 12", log_q.size()); else n_pass++;
    for (int k = 0; k < 12; k++) begin
      exp_q.push_back({2'(k % 4), 32'(16 * (k % 4) + k / 4)});
      n_chk++;
      if (log_q[k] !== exp_q[k]) $display("FAIL fair_evt[%0d]: got %h expected %h", k, log_q[k], exp_q[k]);
      else n_pass++;
    end
    for (int k = 1; k < 12; k++) begin
      n_chk++;
      if (log_cyc[k] - log_cyc[k-1] != 2)
        $display("FAIL fair_gap[%0d]: got %0d expected 2", k, log_cyc[k] - log_cyc[k-1]);
      else n_pass++;
    end
    n_chk++; if (multi_rdy) $display("FAIL fair_onehot: got multiple ready bits expected at most one"); else n_pass++;
  endtask

  task automatic test_burst_limit();
    use_b1 = 1'b0;
    do_reset();
    src_on[2] = 1'b1; src_lim[2] = 16; src_base[2] = 32'h100;
    drive_src();
    tick();
    src_on[0] = 1'b1; src_lim[0] = 1; src_base[0] = 32'hA0;
    drive_src();
    repeat (40) tick();
    for (int k = 0; k < 8; k++) exp_q.push_back({2'd2, 32'(32'h100 + k)});
    exp_q.push_back({2'd0, 32'hA0});
    for (int k = 8; k < 16; k++) exp_q.push_back({2'd2, 32'(32'h100 + k)});
    n_chk++; if (log_q.size() != 17) $display("FAIL burst_count: got %0d expected 17", log_q.size()); else n_pass++;
    for (int k = 0; k < 17; k++) begin
      n_chk++;
      if (log_q[k] !== exp_q[k]) $display("FAIL burst_evt[%0d]: got %h expected %h", k, log_q[k], exp_q[k]);
      else n_pass++;
    end
    n_chk++; if (multi_rdy) $display("FAIL burst_onehot: got multiple ready bits expected at most one"); else n_pass++;
  endtask

  task automatic test_backpressure();
    use_b1 = 1'b0;
    do_reset();
    evt_rdy_in = 1'b0;
    src_on[1] = 1'b1; src_lim[1] = 6; src_base[1] = 32'h200;
    drive_src();
    repeat (10) tick();
    n_chk++; if (src_cnt[1] != 2) $display("FAIL bp_accepts: got %0d expected 2", src_cnt[1]); else n_pass++;
    n_chk++; if (rdy_o[1] !== 1'b0) $display("FAIL bp_rdy1: got %b expected 0", rdy_o[1]); else n_pass++;
    n_chk++; if (vld_o !== 1'b1) $display("FAIL bp_vld: got %b expected 1", vld_o); else n_pass++;
    n_chk++; if (dat_o !== 32'h200) $display("FAIL bp_hold_dat: got %h expected 00000200", dat_o); else n_pass++;
    n_chk++; if (idx_o !== 2'd1) $display("FAIL bp_hold_idx: got %0d expected 1", idx_o); else n_pass++;
    n_chk++; if (stall_chg) $display("FAIL bp_stable: got output change during stall expected stable"); else n_pass++;
    evt_rdy_in = 1'b1;
    repeat (15) tick();
    n_chk++; if (log_q.size() != 6) $display("FAIL bp_count: got %0d expected 6", log_q.size()); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back({2'd1, 32'(32'h200 + k)});
      n_chk++;
      if (log_q[k] !== exp_q[k]) $display("FAIL bp_evt[%0d]: got %h expected %h", k, log_q[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_disable_mid_burst();
    use_b1 = 1'b0;
    do_reset();
    src_on[3] = 1'b1; src_lim[3] = 10; src_base[3] = 32'h300;
    drive_src();
    for (int k = 0; k < 20 && src_cnt[3] < 3; k++) tick();
    n_chk++; if (src_cnt[3] != 3) $display("FAIL dis_reach3: got %0d expected 3", src_cnt[3]); else n_pass++;
    n_chk++; if (rdy_o[3] !== 1'b1) $display("FAIL dis_rdy_before: got %b expected 1", rdy_o[3]); else n_pass++;
    arb_en_in[3] = 1'b0;
    #1;
    n_chk++; if (rdy_o[3] !== 1'b0) $display("FAIL dis_rdy_same_cycle: got %b expected 0", rdy_o[3]); else n_pass++;
    src_on[1] = 1'b1; src_lim[1] = 1; src_base[1] = 32'h250;
    drive_src();
    repeat (12) tick();
    n_chk++; if (src_cnt[3] != 3) $display("FAIL dis_no_regrant: got %0d expected 3", src_cnt[3]); else n_pass++;
    for (int k = 0; k < 3; k++) exp_q.push_back({2'd3, 32'(32'h300 + k)});
    exp_q.push_back({2'd1, 32'h250});
    n_chk++; if (log_q.size() != 4) $display("FAIL dis_count: got %0d expected 4", log_q.size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (log_q[k] !== exp_q[k]) $display("FAIL dis_evt[%0d]: got %h expected %h", k, log_q[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_early_release();
    use_b1 = 1'b0;
    do_reset();
    src_on[0] = 1'b1; src_lim[0] = 2; src_base[0] = 32'h400;
    src_on[1] = 1'b1; src_lim[1] = 2; src_base[1] = 32'h410;
    drive_src();
    repeat (14) tick();
    n_chk++;
    if (first_acc[1] - last_acc[0] != 3)
      $display("FAIL early_gap: got %0d expected 3", first_acc[1] - last_acc[0]);
    else n_pass++;
    exp_q.push_back({2'd0, 32'h400}); exp_q.push_back({2'd0, 32'h401});
    exp_q.push_back({2'd1, 32'h410}); exp_q.push_back({2'd1, 32'h411});
    n_chk++; if (log_q.size() != 4) $display("FAIL early_count: got %0d expected 4", log_q.size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (log_q[k] !== exp_q[k]) $display("FAIL early_evt[%0d]: got %h expected %h", k, log_q[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    use_b1 = 1'b0;
    do_reset();
    evt_rdy_in = 1'b0;
    src_on[2] = 1'b1; src_lim[2] = 5; src_base[2] = 32'h500;
    drive_src();
    repeat (5) tick();
    n_chk++; if (src_cnt[2] != 2) $display("FAIL rmid_full: got %0d expected 2", src_cnt[2]); else n_pass++;
    n_chk++; if (vld_o !== 1'b1) $display("FAIL rmid_vld_pre: got %b expected 1", vld_o); else n_pass++;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_chk++; if (vld_o !== 1'b0) $display("FAIL rmid_vld: got %b expected 0", vld_o); else n_pass++;
    n_chk++; if (dat_o !== 32'h0) $display("FAIL rmid_dat: got %h expected 0", dat_o); else n_pass++;
    n_chk++; if (idx_o !== 2'd0) $display("FAIL rmid_idx: got %0d expected 0", idx_o); else n_pass++;
    n_chk++; if (rdy_o !== '0) $display("FAIL rmid_rdy: got %b expected 0000", rdy_o); else n_pass++;
    clear_src();
    src_on[0] = 1'b1; src_lim[0] = 1; src_base[0] = 32'h600;
    src_on[2] = 1'b1; src_lim[2] = 1; src_base[2] = 32'h610;
    evt_rdy_in = 1'b1;
    drive_src();
    repeat (10) tick();
    exp_q.push_back({2'd0, 32'h600}); exp_q.push_back({2'd2, 32'h610});
    n_chk++; if (log_q.size() != 2) $display("FAIL rmid_count: got %0d expected 2", log_q.size()); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (log_q[k] !== exp_q[k]) $display("FAIL rmid_evt[%0d]: got %h expected %h", k, log_q[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc = 0;
    use_b1 = 1'b0;
    reset = 1'b0;
    arb_en_in = '1;
    evt_rdy_in = 1'b1;
    test_reset();
    test_fair_rotation();
    test_burst_limit();
    test_backpressure();
    test_disable_mid_burst();
    test_early_release();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
